// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: phase strobes, per-bit decision capture, weighted code, 1-deep result buffer.
// Result valid 3+SAMP_CYCLES+2*RES cycles after start; a result arriving at a full, unread buffer is dropped and flagged.
module sar_sequencer #(
  parameter int RES         = 16,
  parameter int SAMP_CYCLES = 4,
  parameter int WEIGHT_W    = 16,
  parameter int CODE_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  input  logic [1:0]              samp_sel,
  input  logic [RES*WEIGHT_W-1:0] weights,
  input  logic                    comp_in,
  output logic                    seq_init,
  output logic                    seq_samp,
  output logic                    seq_comp,
  output logic                    seq_update,
  output logic                    en_init,
  output logic                    en_samp_p,
  output logic                    en_samp_n,
  output logic                    en_comp,
  output logic                    en_update,
  output logic [3:0]              bit_idx,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [RES-1:0]          result_bits,
  output logic [CODE_W-1:0]       result_code,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int              CNT_W     = (SAMP_CYCLES > 1) ? $clog2(SAMP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMP_CYCLES - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(RES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SAMP, S_COMP, S_UPDATE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [3:0]                 idx_q, idx_d;
  logic [1:0]                 sel_q, sel_d;
  logic [RES-1:0]             wbits_q, wbits_d;
  logic [CODE_W-1:0]          wcode_q, wcode_d;
  logic [RES-1:0]             rbits_d;
  logic [CODE_W-1:0]          rcode_d;
  logic                       rvalid_d, ovr_d, busy_d;
  logic [WEIGHT_W-1:0]        w_sel;
  logic [CODE_W+WEIGHT_W-1:0] w_ext;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < RES; k++)
      if (idx_q == 4'(k)) w_sel = weights[k*WEIGHT_W +: WEIGHT_W];
  end

  // Zero-extend then keep the low CODE_W bits, so the add wraps modulo 2^CODE_W.
  assign w_ext = {{CODE_W{1'b0}}, w_sel};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    wbits_d  = wbits_q;
    wcode_d  = wcode_q;
    rbits_d  = result_bits;
    rcode_d  = result_code;
    rvalid_d = result_valid & ~result_ready;
    ovr_d    = overrun & ~overrun_clr;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_INIT;
            sel_d   = samp_sel;
          end
        end
        S_INIT: begin
          state_d = S_SAMP;
          cnt_d   = '0;
          wbits_d = '0;
          wcode_d = '0;
        end
        S_SAMP: begin
          if (cnt_q == SAMP_LAST) begin
            state_d = S_COMP;
            idx_d   = BIT_LAST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_COMP: state_d = S_UPDATE;
        S_UPDATE: begin
          for (int k = 0; k < RES; k++)
            if (idx_q == 4'(k)) wbits_d[k] = comp_in;
          if (comp_in) wcode_d = wcode_q + w_ext[CODE_W-1:0];
          if (idx_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COMP;
            idx_d   = idx_q - 4'd1;
          end
        end
        S_DONE: begin
          if (!result_valid || result_ready) begin
            rbits_d  = wbits_q;
            rcode_d  = wcode_q;
            rvalid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = cont ? S_INIT : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      wbits_q      <= '0;
      wcode_q      <= '0;
      seq_init     <= 1'b0;
      seq_samp     <= 1'b0;
      seq_comp     <= 1'b0;
      seq_update   <= 1'b0;
      en_init      <= 1'b0;
      en_samp_p    <= 1'b0;
      en_samp_n    <= 1'b0;
      en_comp      <= 1'b0;
      en_update    <= 1'b0;
      bit_idx      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_bits  <= '0;
      result_code  <= '0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      wbits_q      <= wbits_d;
      wcode_q      <= wcode_d;
      seq_init     <= (state_d == S_INIT);
      seq_samp     <= (state_d == S_SAMP);
      seq_comp     <= (state_d == S_COMP);
      seq_update   <= (state_d == S_UPDATE);
      en_init      <= busy_d;
      en_samp_p    <= busy_d & sel_d[0];
      en_samp_n    <= busy_d & sel_d[1];
      en_comp      <= busy_d;
      en_update    <= busy_d;
      bit_idx      <= (state_d == S_COMP || state_d == S_UPDATE) ? idx_d : 4'd0;
      busy         <= busy_d;
      result_valid <= rvalid_d;
      result_bits  <= rbits_d;
      result_code  <= rcode_d;
      overrun      <= ovr_d;
    end
  end

endmodule
